// File: rtl/dict_wr_ctrl_if.sv
// Pair handshake between the compare stage and the dictionary write controller.
// The compare stage presents two words per beat and flags which ones to insert.
interface dict_wr_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_word0;
  logic [DATA_WIDTH-1:0] i_word1;
  logic                  i_push0;
  logic                  i_push1;
  logic                  i_last;

  modport master (
    output i_valid, i_word0, i_word1, i_push0, i_push1, i_last,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_word0, i_word1, i_push0, i_push1, i_last,
    output o_ready
  );
endinterface

// File: rtl/dict_wr_ctrl.sv
// Dictionary write-side controller: per line it clears the dictionary, compacts and
// de-duplicates insert pairs through a one-pair pending register, and drains at line end.
module dict_wr_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_ENTRY = 16,
  parameter int LINE_PAIRS      = 8,
  localparam int CW             = $clog2(WORDS_PER_ENTRY) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  dict_wr_ctrl_if.slave         pair,
  input  logic                  i_dict_hold,
  output logic                  o_wr,
  output logic                  o_wr2,
  output logic [DATA_WIDTH-1:0] o_w_data,
  output logic [DATA_WIDTH-1:0] o_w_data2,
  output logic                  o_dict_clr,
  output logic [CW-1:0]         o_ins_cnt,
  output logic                  o_line_done,
  output logic                  o_err
);

  localparam int PCW = $clog2(LINE_PAIRS + 2);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                  valid;
    logic                  push0;
    logic                  push1;
    logic [DATA_WIDTH-1:0] word0;
    logic [DATA_WIDTH-1:0] word1;
  } pend_t;

  state_t         state;
  pend_t          pend;
  logic [PCW-1:0] pair_cnt;

  logic           issue;
  logic           accept;
  logic           ready;
  logic [1:0]     n_strobe;
  logic [CW:0]    cnt_sum;

  assign issue  = pend.valid & ~i_dict_hold;
  assign ready  = (state == RUN) & (~pend.valid | ~i_dict_hold);
  assign accept = pair.i_valid & ready;
  assign pair.o_ready = ready;

  // A single push always lands on the first port; identical pairs collapse to one write.
  always_comb begin
    o_wr      = 1'b0;
    o_wr2     = 1'b0;
    o_w_data  = '0;
    o_w_data2 = '0;
    if (issue) begin
      o_wr = 1'b1;
      if (pend.push0 & pend.push1) begin
        o_w_data = pend.word0;
        if (pend.word0 != pend.word1) begin
          o_wr2     = 1'b1;
          o_w_data2 = pend.word1;
        end
      end else if (pend.push0) begin
        o_w_data = pend.word0;
      end else begin
        o_w_data = pend.word1;
      end
    end
  end

  assign n_strobe = {1'b0, o_wr} + {1'b0, o_wr2};
  assign cnt_sum  = {1'b0, o_ins_cnt} + (CW+1)'(n_strobe);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      pend        <= '0;
      pair_cnt    <= '0;
      o_dict_clr  <= 1'b0;
      o_ins_cnt   <= '0;
      o_line_done <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_dict_clr  <= 1'b0;
      o_line_done <= 1'b0;

      // Load and drain share an edge so back-to-back beats sustain one pair per cycle.
      if (accept) begin
        pend.valid <= pair.i_push0 | pair.i_push1;
        pend.push0 <= pair.i_push0;
        pend.push1 <= pair.i_push1;
        pend.word0 <= pair.i_word0;
        pend.word1 <= pair.i_word1;
      end else if (issue) begin
        pend.valid <= 1'b0;
      end

      if (issue)
        o_ins_cnt <= (cnt_sum > (CW+1)'(WORDS_PER_ENTRY)) ? CW'(WORDS_PER_ENTRY)
                                                          : cnt_sum[CW-1:0];

      case (state)
        IDLE: begin
          if (i_start) begin
            state      <= CLEAR;
            o_dict_clr <= 1'b1;
            o_ins_cnt  <= '0;
            pair_cnt   <= '0;
            o_err      <= 1'b0;
          end
        end
        CLEAR: state <= RUN;
        RUN: begin
          if (accept) begin
            if (pair_cnt == PCW'(LINE_PAIRS)) o_err <= 1'b1;
            if (pair_cnt != PCW'(LINE_PAIRS + 1)) pair_cnt <= pair_cnt + 1'b1;
            if (pair.i_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pend.valid) begin
            state       <= DONE;
            o_line_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dict_wr_ctrl.sv
// Directed bench for dict_wr_ctrl: line start/clear, compaction, dedup, hold, drain,
// saturation, protocol error and mid-line reset, with hand-computed expectations.
module tb_dict_wr_ctrl;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        hold;
  logic        wr, wr2, clr, done, err;
  logic [31:0] wd, wd2;
  logic [4:0]  cnt;
  int          n_tests;
  int          n_fail;

  dict_wr_ctrl_if #(.DATA_WIDTH(32)) pif ();

  dict_wr_ctrl #(.DATA_WIDTH(32), .WORDS_PER_ENTRY(16), .LINE_PAIRS(8)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .pair(pif), .i_dict_hold(hold),
    .o_wr(wr), .o_wr2(wr2), .o_w_data(wd), .o_w_data2(wd2), .o_dict_clr(clr),
    .o_ins_cnt(cnt), .o_line_done(done), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w0, input logic [31:0] w1,
                       input logic p0, input logic p1, input logic l);
    pif.i_valid = v; pif.i_word0 = w0; pif.i_word1 = w1;
    pif.i_push0 = p0; pif.i_push1 = p1; pif.i_last = l;
  endtask

  task automatic start_line();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    n_tests++; if (wr !== 1'b0)   begin n_fail++; $display("FAIL reset_wr: got %0h exp 0", wr); end
    n_tests++; if (wr2 !== 1'b0)  begin n_fail++; $display("FAIL reset_wr2: got %0h exp 0", wr2); end
    n_tests++; if (wd !== 32'h0)  begin n_fail++; $display("FAIL reset_wd: got %h exp 0", wd); end
    n_tests++; if (wd2 !== 32'h0) begin n_fail++; $display("FAIL reset_wd2: got %h exp 0", wd2); end
    n_tests++; if (clr !== 1'b0)  begin n_fail++; $display("FAIL reset_clr: got %0h exp 0", clr); end
    n_tests++; if (cnt !== 5'd0)  begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", cnt); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0h exp 0", done); end
    n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %0h exp 0", err); end
    n_tests++; if (pif.o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0h exp 0", pif.o_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_start();
    start_line();
    n_tests++; if (clr !== 1'b1) begin n_fail++; $display("FAIL start_clr: got %0h exp 1", clr); end
    n_tests++; if (pif.o_ready !== 1'b0) begin n_fail++; $display("FAIL start_ready_clear: got %0h exp 0", pif.o_ready); end
    tick();
    n_tests++; if (clr !== 1'b0) begin n_fail++; $display("FAIL start_clr_once: got %0h exp 0", clr); end
    n_tests++; if (pif.o_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready_run: got %0h exp 1", pif.o_ready); end
  endtask

  task automatic test_pair();
    drive(1'b1, 32'hDEADBEEF, 32'hCAFEBABE, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++; if ({wr, wr2} !== 2'b11) begin n_fail++; $display("FAIL pair_strobes: got %b exp 11", {wr, wr2}); end
    n_tests++; if (wd !== 32'hDEADBEEF)  begin n_fail++; $display("FAIL pair_wd: got %h exp deadbeef", wd); end
    n_tests++; if (wd2 !== 32'hCAFEBABE) begin n_fail++; $display("FAIL pair_wd2: got %h exp cafebabe", wd2); end
    tick();
    n_tests++; if (cnt !== 5'd2) begin n_fail++; $display("FAIL pair_cnt: got %0d exp 2", cnt); end
    n_tests++; if (wr !== 1'b0)  begin n_fail++; $display("FAIL pair_idle_wr: got %0h exp 0", wr); end
  endtask

  task automatic test_compact_dedup();
    drive(1'b1, 32'hFFFF0000, 32'h12345678, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++; if ({wr, wr2} !== 2'b10) begin n_fail++; $display("FAIL compact_strobes: got %b exp 10", {wr, wr2}); end
    n_tests++; if (wd !== 32'h12345678) begin n_fail++; $display("FAIL compact_wd: got %h exp 12345678", wd); end
    n_tests++; if (wd2 !== 32'h0)       begin n_fail++; $display("FAIL compact_wd2: got %h exp 0", wd2); end
    tick();
    drive(1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++; if ({wr, wr2} !== 2'b10) begin n_fail++; $display("FAIL dedup_strobes: got %b exp 10", {wr, wr2}); end
    n_tests++; if (wd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL dedup_wd: got %h exp a5a5a5a5", wd); end
    tick();
    n_tests++; if (cnt !== 5'd4) begin n_fail++; $display("FAIL dedup_cnt: got %0d exp 4", cnt); end
  endtask

  task automatic test_hold();
    drive(1'b1, 32'h11111111, 32'h22222222, 1'b1, 1'b1, 1'b0);
    tick();
    hold = 1'b1;
    drive(1'b1, 32'h33333333, 32'h44444444, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if ({wr, wr2} !== 2'b00) begin n_fail++; $display("FAIL hold_strobes[%0d]: got %b exp 00", i, {wr, wr2}); end
      n_tests++; if (pif.o_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %0h exp 0", i, pif.o_ready); end
      tick();
    end
    n_tests++; if (cnt !== 5'd4) begin n_fail++; $display("FAIL hold_cnt: got %0d exp 4", cnt); end
    hold = 1'b0;
    #1;
    n_tests++; if (pif.o_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %0h exp 1", pif.o_ready); end
    n_tests++; if ({wr, wr2} !== 2'b11)  begin n_fail++; $display("FAIL release_strobes: got %b exp 11", {wr, wr2}); end
    n_tests++; if (wd !== 32'h11111111 || wd2 !== 32'h22222222)
      begin n_fail++; $display("FAIL release_data: got %h/%h exp 11111111/22222222", wd, wd2); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++; if (wd !== 32'h33333333 || wd2 !== 32'h44444444)
      begin n_fail++; $display("FAIL next_data: got %h/%h exp 33333333/44444444", wd, wd2); end
    tick();
    n_tests++; if (cnt !== 5'd8) begin n_fail++; $display("FAIL hold_cnt_after: got %0d exp 8", cnt); end
    // beat with no push is accepted but issues nothing
    drive(1'b1, 32'h77777777, 32'h88888888, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++; if (wr !== 1'b0) begin n_fail++; $display("FAIL nopush_wr: got %0h exp 0", wr); end
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++; if (pif.o_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %0h exp 0", pif.o_ready); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL drain_done_early: got %0h exp 0", done); end
    tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL line1_done: got %0h exp 1", done); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL line1_done_once: got %0h exp 0", done); end
    n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL line1_err: got %0h exp 0", err); end
    n_tests++; if (cnt !== 5'd8)  begin n_fail++; $display("FAIL line1_cnt: got %0d exp 8", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e0, e1;
    start_line();
    tick();
    n_tests++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL b2b_cnt_clr: got %0d exp 0", cnt); end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h100 + 32'(2*k), 32'h101 + 32'(2*k), 1'b1, 1'b1, k == 7);
      #1;
      n_tests++; if (pif.o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0h exp 1", k, pif.o_ready); end
      if (k > 0) begin
        e0 = 32'h100 + 32'(2*(k-1)); e1 = e0 + 32'h1;
        n_tests++; if (wr !== 1'b1 || wd !== e0 || wd2 !== e1)
          begin n_fail++; $display("FAIL b2b_write[%0d]: got %0h %h/%h exp 1 %h/%h", k, wr, wd, wd2, e0, e1); end
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++; if (pif.o_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_ready: got %0h exp 0", pif.o_ready); end
    n_tests++; if (wd !== 32'h10E || wd2 !== 32'h10F) begin n_fail++; $display("FAIL b2b_last_data: got %h/%h exp 10e/10f", wd, wd2); end
    n_tests++; if (cnt !== 5'd14) begin n_fail++; $display("FAIL b2b_cnt14: got %0d exp 14", cnt); end
    tick();
    n_tests++; if (cnt !== 5'd16) begin n_fail++; $display("FAIL b2b_cnt16: got %0d exp 16", cnt); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_early: got %0h exp 0", done); end
    tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %0h exp 1", done); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_once: got %0h exp 0", done); end
    n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL b2b_err: got %0h exp 0", err); end
  endtask

  task automatic test_err_sat();
    start_line();
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h200 + 32'(2*k), 32'h201 + 32'(2*k), 1'b1, 1'b1, k == 9);
      #1;
      if (k == 8) begin
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_early: got %0h exp 0", err); end
      end
      if (k == 9) begin
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %0h exp 1", err); end
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (clr !== 1'b0) begin n_fail++; $display("FAIL start_ignored: got %0h exp 0", clr); end
    tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL err_line_done: got %0h exp 1", done); end
    tick();
    n_tests++; if (cnt !== 5'd16) begin n_fail++; $display("FAIL sat_cnt: got %0d exp 16", cnt); end
    n_tests++; if (err !== 1'b1)  begin n_fail++; $display("FAIL err_sticky: got %0h exp 1", err); end
  endtask

  task automatic test_reset_midline();
    start_line();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %0h exp 0", err); end
    tick();
    drive(1'b1, 32'h55555555, 32'h66666666, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++; if (wr !== 1'b1) begin n_fail++; $display("FAIL midline_pending: got %0h exp 1", wr); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({wr, wr2} !== 2'b00) begin n_fail++; $display("FAIL midline_rst_strobes: got %b exp 00", {wr, wr2}); end
    n_tests++; if (wd !== 32'h0 || wd2 !== 32'h0) begin n_fail++; $display("FAIL midline_rst_data: got %h/%h exp 0/0", wd, wd2); end
    n_tests++; if (pif.o_ready !== 1'b0) begin n_fail++; $display("FAIL midline_rst_ready: got %0h exp 0", pif.o_ready); end
    n_tests++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL midline_rst_cnt: got %0d exp 0", cnt); end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if ({wr, done, pif.o_ready} !== 3'b000)
        begin n_fail++; $display("FAIL post_reset[%0d]: got wr/done/ready=%b exp 000", i, {wr, done, pif.o_ready}); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_start();
    test_pair();
    test_compact_dedup();
    test_hold();
    test_back_to_back();
    test_err_sat();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
